// File: rtl/stage_id_pipe.sv
// -----------------------------------------------------------------------------
// stage_id_pipe
//   Instruction decode stage. Decodes a raw RV32I-class instruction, reads the
//   internal register file, resolves rs1/rs2 through NUM_FWD prioritised
//   forwarding sources (index 0 = youngest = highest priority), detects
//   load-use hazards and registers everything into the ID/EX register.
//
//   Handshake (both sides): a transfer happens on a rising edge where valid
//   and ready are both high. valid never depends on ready of the same side;
//   once out_valid_o is high the payload holds until out_ready_i accepts it
//   (or flush_i / rst_i clears it). in_ready_o is forced high during flush_i
//   so IF can drop the killed instruction.
//
//   Optional feature macro: RF_WRITE_BYPASS_EN
//     defined   : a same-cycle RF write to a register being read is returned
//                 (write-through), below all forwarding sources in priority.
//     undefined : reads return the old contents; the write is visible from
//                 the next cycle.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o upstream handshake (from stage_if)
//   instruction_i, pc_i   raw instruction and its address
//   flush_i               kill in-flight and incoming instruction
//   rf_we_i/rd_i/rf_wd_i  register-file write-back port
//   fwd_valid_i           per source: holds a register-writing instruction
//   fwd_pending_i         per source: data not yet available (load in flight)
//   fwd_rd_i, fwd_dat_i   per source destination register / data (packed)
//   out_valid_o/out_ready_i downstream handshake (to stage_ex)
//   funct3_o, rs1_o, rs2_o, rd_o, alu_op_o, dat_a_o, dat_b_o, store_dat_o,
//   imm_o, csr_addr_o, is_*_o class flags, e_illegal_inst_o : ID/EX payload
// -----------------------------------------------------------------------------
module stage_id_pipe #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_FWD  = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [31:0]               instruction_i,
   input  logic [XLEN-1:0]           pc_i,
   input  logic                      flush_i,
   input  logic                      rf_we_i,
   input  logic [4:0]                rd_i,
   input  logic [XLEN-1:0]           rf_wd_i,
   input  logic [NUM_FWD-1:0]        fwd_valid_i,
   input  logic [NUM_FWD-1:0]        fwd_pending_i,
   input  logic [5*NUM_FWD-1:0]      fwd_rd_i,
   input  logic [XLEN*NUM_FWD-1:0]   fwd_dat_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [2:0]                funct3_o,
   output logic [4:0]                rs1_o,
   output logic [4:0]                rs2_o,
   output logic [4:0]                rd_o,
   output logic [3:0]                alu_op_o,
   output logic [XLEN-1:0]           dat_a_o,
   output logic [XLEN-1:0]           dat_b_o,
   output logic [XLEN-1:0]           store_dat_o,
   output logic [XLEN-1:0]           imm_o,
   output logic [11:0]               csr_addr_o,
   output logic                      is_op_o,
   output logic                      is_lui_o,
   output logic                      is_auipc_o,
   output logic                      is_jal_o,
   output logic                      is_jalr_o,
   output logic                      is_branch_o,
   output logic                      is_load_o,
   output logic                      is_store_o,
   output logic                      is_misc_mem_o,
   output logic                      is_system_o,
   output logic                      e_illegal_inst_o
);

   localparam int         RAW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [5:0] NREGS6 = 6'(NUM_REGS);

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // ---------------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] rf [NUM_REGS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
      end else if (rf_we_i && rd_i != 5'd0 && {1'b0, rd_i} < NREGS6) begin
         rf[rd_i[RAW-1:0]] <= rf_wd_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Field extraction and class decode
   // ---------------------------------------------------------------------------
   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = instruction_i[6:0];
   assign f3     = instruction_i[14:12];
   assign rs1    = instruction_i[19:15];
   assign rs2    = instruction_i[24:20];
   assign rd     = instruction_i[11:7];

   // Casting a signed value to XLEN bits sign-extends it.
   assign imm_i = XLEN'($signed(instruction_i[31:20]));
   assign imm_s = XLEN'($signed({instruction_i[31:25], instruction_i[11:7]}));
   assign imm_b = XLEN'($signed({instruction_i[31], instruction_i[7],
                                 instruction_i[30:25], instruction_i[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({instruction_i[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({instruction_i[31], instruction_i[19:12],
                                 instruction_i[20], instruction_i[30:21], 1'b0}));

   // Raw class flags straight from the opcode (before the illegal mask).
   logic c_op, c_op_imm, c_lui, c_auipc, c_jal, c_jalr, c_branch;
   logic c_load, c_store, c_misc_mem, c_system, opc_known;
   logic use_rs1, use_rs2, use_rd, range_bad, illegal;

   always_comb begin
      c_op       = 1'b0;
      c_op_imm   = 1'b0;
      c_lui      = 1'b0;
      c_auipc    = 1'b0;
      c_jal      = 1'b0;
      c_jalr     = 1'b0;
      c_branch   = 1'b0;
      c_load     = 1'b0;
      c_store    = 1'b0;
      c_misc_mem = 1'b0;
      c_system   = 1'b0;
      opc_known  = 1'b1;
      case (opcode)
         OPC_OP:       c_op       = 1'b1;
         OPC_OP_IMM:   c_op_imm   = 1'b1;
         OPC_LUI:      c_lui      = 1'b1;
         OPC_AUIPC:    c_auipc    = 1'b1;
         OPC_JAL:      c_jal      = 1'b1;
         OPC_JALR:     c_jalr     = 1'b1;
         OPC_BRANCH:   c_branch   = 1'b1;
         OPC_LOAD:     c_load     = 1'b1;
         OPC_STORE:    c_store    = 1'b1;
         OPC_MISC_MEM: c_misc_mem = 1'b1;
         OPC_SYSTEM:   c_system   = 1'b1;
         default:      opc_known  = 1'b0;
      endcase

      // CSR register forms (funct3 = 1..3) read rs1; all CSR forms write rd.
      use_rs1 = c_op | c_op_imm | c_jalr | c_branch | c_load | c_store |
                (c_system & ~f3[2] & (f3 != 3'b000));
      use_rs2 = c_op | c_branch | c_store;
      use_rd  = c_op | c_op_imm | c_lui | c_auipc | c_jal | c_jalr | c_load |
                (c_system & (f3 != 3'b000));

      // Register indices beyond NUM_REGS (E-variant) make the instruction illegal.
      range_bad = (use_rs1 && {1'b0, rs1} >= NREGS6) ||
                  (use_rs2 && {1'b0, rs2} >= NREGS6) ||
                  (use_rd  && {1'b0, rd}  >= NREGS6);

      illegal = (opcode[1:0] != 2'b11) || !opc_known || range_bad;
   end

   // ---------------------------------------------------------------------------
   // Operand read: RF (optionally write-through), then forwarding override.
   // Slot 0 = rs1, slot 1 = rs2.
   // ---------------------------------------------------------------------------
   logic [4:0]      rs_sel   [2];
   logic [XLEN-1:0] rf_val   [2];
   logic [XLEN-1:0] opnd     [2];
   logic            fwd_hit  [2];
   logic            fwd_pend [2];

   always_comb begin
      rs_sel[0] = rs1;
      rs_sel[1] = rs2;
      for (int s = 0; s < 2; s++) begin
         rf_val[s] = '0;
         if (rs_sel[s] != 5'd0 && {1'b0, rs_sel[s]} < NREGS6) begin
            rf_val[s] = rf[rs_sel[s][RAW-1:0]];
         end
`ifdef RF_WRITE_BYPASS_EN
         if (rf_we_i && rd_i == rs_sel[s] && rs_sel[s] != 5'd0 &&
             {1'b0, rd_i} < NREGS6) begin
            rf_val[s] = rf_wd_i;
         end
`endif
         opnd[s]     = rf_val[s];
         fwd_hit[s]  = 1'b0;
         fwd_pend[s] = 1'b0;
         // Walk from the oldest source down so the lowest matching index wins.
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid_i[k] && fwd_rd_i[k*5 +: 5] == rs_sel[s] &&
                rs_sel[s] != 5'd0) begin
               opnd[s]     = fwd_dat_i[k*XLEN +: XLEN];
               fwd_hit[s]  = 1'b1;
               fwd_pend[s] = fwd_pending_i[k];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Hazard and handshake
   // ---------------------------------------------------------------------------
   logic hazard, adv, accept;

   assign hazard = in_valid_i &&
                   ((use_rs1 && fwd_hit[0] && fwd_pend[0]) ||
                    (use_rs2 && fwd_hit[1] && fwd_pend[1]));
   assign adv        = out_ready_i || !out_valid_o;
   assign in_ready_o = flush_i || (adv && !hazard);
   assign accept     = !flush_i && adv && in_valid_i && !hazard;

   // ---------------------------------------------------------------------------
   // Next payload (final classes are masked by illegal)
   // ---------------------------------------------------------------------------
   logic            n_op, n_lui, n_auipc, n_jal, n_jalr, n_branch;
   logic            n_load, n_store, n_misc_mem, n_system;
   logic [3:0]      n_alu_op;
   logic [XLEN-1:0] n_imm, n_dat_a, n_dat_b;
   logic [11:0]     n_csr;

   always_comb begin
      n_op       = (c_op | c_op_imm) & ~illegal;
      n_lui      = c_lui      & ~illegal;
      n_auipc    = c_auipc    & ~illegal;
      n_jal      = c_jal      & ~illegal;
      n_jalr     = c_jalr     & ~illegal;
      n_branch   = c_branch   & ~illegal;
      n_load     = c_load     & ~illegal;
      n_store    = c_store    & ~illegal;
      n_misc_mem = c_misc_mem & ~illegal;
      n_system   = c_system   & ~illegal;

      n_imm = '0;
      if (c_op_imm || c_load || c_jalr || c_system) n_imm = imm_i;
      if (c_store)                                  n_imm = imm_s;
      if (c_branch)                                 n_imm = imm_b;
      if (c_lui || c_auipc)                         n_imm = imm_u;
      if (c_jal)                                    n_imm = imm_j;
      if (illegal)                                  n_imm = '0;

      // funct7[5] only selects SUB/SRA; for OP-IMM it is imm bits except on shifts.
      n_alu_op = 4'b0000;
      if (c_op)     n_alu_op = {instruction_i[30], f3};
      if (c_op_imm) n_alu_op = (f3 == 3'b001 || f3 == 3'b101) ?
                               {instruction_i[30], f3} : {1'b0, f3};
      if (illegal)  n_alu_op = 4'b0000;

      n_dat_a = '0;
      if (n_op || n_jalr || n_branch || n_load || n_store || n_system) n_dat_a = opnd[0];
      if (n_auipc || n_jal)                                          n_dat_a = pc_i;

      n_dat_b = n_imm;
      if (n_op && c_op)     n_dat_b = opnd[1];
      if (n_branch)         n_dat_b = opnd[1];
      if (n_jal || n_jalr)  n_dat_b = XLEN'(4);

      n_csr = n_system ? instruction_i[31:20] : 12'd0;
   end

   // ---------------------------------------------------------------------------
   // ID/EX register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o      <= 1'b0;
         funct3_o         <= '0;
         rs1_o            <= '0;
         rs2_o            <= '0;
         rd_o             <= '0;
         alu_op_o         <= '0;
         dat_a_o          <= '0;
         dat_b_o          <= '0;
         store_dat_o      <= '0;
         imm_o            <= '0;
         csr_addr_o       <= '0;
         is_op_o          <= 1'b0;
         is_lui_o         <= 1'b0;
         is_auipc_o       <= 1'b0;
         is_jal_o         <= 1'b0;
         is_jalr_o        <= 1'b0;
         is_branch_o      <= 1'b0;
         is_load_o        <= 1'b0;
         is_store_o       <= 1'b0;
         is_misc_mem_o    <= 1'b0;
         is_system_o      <= 1'b0;
         e_illegal_inst_o <= 1'b0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
      end else if (adv) begin
         // A hazard with adv high leaves a bubble behind.
         out_valid_o <= in_valid_i && !hazard;
         if (accept) begin
            funct3_o         <= f3;
            rs1_o            <= rs1;
            rs2_o            <= rs2;
            rd_o             <= rd;
            alu_op_o         <= n_alu_op;
            dat_a_o          <= n_dat_a;
            dat_b_o          <= n_dat_b;
            store_dat_o      <= opnd[1];
            imm_o            <= n_imm;
            csr_addr_o       <= n_csr;
            is_op_o          <= n_op;
            is_lui_o         <= n_lui;
            is_auipc_o       <= n_auipc;
            is_jal_o         <= n_jal;
            is_jalr_o        <= n_jalr;
            is_branch_o      <= n_branch;
            is_load_o        <= n_load;
            is_store_o       <= n_store;
            is_misc_mem_o    <= n_misc_mem;
            is_system_o      <= n_system;
            e_illegal_inst_o <= illegal;
         end
      end
   end

endmodule

// File: tb/tb_stage_id_pipe.sv
// -----------------------------------------------------------------------------
// tb_stage_id_pipe
//   Directed bench for stage_id_pipe. A second instance with NUM_REGS=16
//   shares all inputs and is used for the E-variant register range check.
// -----------------------------------------------------------------------------
module tb_stage_id_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] instruction = '0;
   logic [31:0] pc = '0;
   logic        flush = 1'b0;
   logic        rf_we = 1'b0;
   logic [4:0]  rd_in = '0;
   logic [31:0] rf_wd = '0;
   logic [1:0]  fwd_valid = '0;
   logic [1:0]  fwd_pending = '0;
   logic [9:0]  fwd_rd = '0;
   logic [63:0] fwd_dat = '0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [3:0]  alu_op;
   logic [31:0] dat_a, dat_b, store_dat, imm;
   logic [11:0] csr_addr;
   logic        is_op, is_lui, is_auipc, is_jal, is_jalr, is_branch;
   logic        is_load, is_store, is_misc_mem, is_system, illegal;

   logic        e_in_ready, e_out_valid;
   logic [2:0]  e_funct3;
   logic [4:0]  e_rs1, e_rs2, e_rd;
   logic [3:0]  e_alu_op;
   logic [31:0] e_dat_a, e_dat_b, e_store_dat, e_imm;
   logic [11:0] e_csr_addr;
   logic        e_is_op, e_is_lui, e_is_auipc, e_is_jal, e_is_jalr, e_is_branch;
   logic        e_is_load, e_is_store, e_is_misc_mem, e_is_system, e_illegal;

   logic [9:0]  flags, e_flags;
   assign flags   = {is_op, is_lui, is_auipc, is_jal, is_jalr, is_branch,
                     is_load, is_store, is_misc_mem, is_system};
   assign e_flags = {e_is_op, e_is_lui, e_is_auipc, e_is_jal, e_is_jalr, e_is_branch,
                     e_is_load, e_is_store, e_is_misc_mem, e_is_system};

   int pass_cnt  = 0;
   int total_cnt = 0;

   stage_id_pipe #(.XLEN(32), .NUM_REGS(32), .NUM_FWD(2)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instruction_i(instruction), .pc_i(pc), .flush_i(flush),
      .rf_we_i(rf_we), .rd_i(rd_in), .rf_wd_i(rf_wd),
      .fwd_valid_i(fwd_valid), .fwd_pending_i(fwd_pending),
      .fwd_rd_i(fwd_rd), .fwd_dat_i(fwd_dat),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .funct3_o(funct3), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .alu_op_o(alu_op),
      .dat_a_o(dat_a), .dat_b_o(dat_b), .store_dat_o(store_dat), .imm_o(imm),
      .csr_addr_o(csr_addr), .is_op_o(is_op), .is_lui_o(is_lui),
      .is_auipc_o(is_auipc), .is_jal_o(is_jal), .is_jalr_o(is_jalr),
      .is_branch_o(is_branch), .is_load_o(is_load), .is_store_o(is_store),
      .is_misc_mem_o(is_misc_mem), .is_system_o(is_system),
      .e_illegal_inst_o(illegal)
   );

   stage_id_pipe #(.XLEN(32), .NUM_REGS(16), .NUM_FWD(2)) dut_e (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(e_in_ready),
      .instruction_i(instruction), .pc_i(pc), .flush_i(flush),
      .rf_we_i(rf_we), .rd_i(rd_in), .rf_wd_i(rf_wd),
      .fwd_valid_i(fwd_valid), .fwd_pending_i(fwd_pending),
      .fwd_rd_i(fwd_rd), .fwd_dat_i(fwd_dat),
      .out_valid_o(e_out_valid), .out_ready_i(out_ready),
      .funct3_o(e_funct3), .rs1_o(e_rs1), .rs2_o(e_rs2), .rd_o(e_rd), .alu_op_o(e_alu_op),
      .dat_a_o(e_dat_a), .dat_b_o(e_dat_b), .store_dat_o(e_store_dat), .imm_o(e_imm),
      .csr_addr_o(e_csr_addr), .is_op_o(e_is_op), .is_lui_o(e_is_lui),
      .is_auipc_o(e_is_auipc), .is_jal_o(e_is_jal), .is_jalr_o(e_is_jalr),
      .is_branch_o(e_is_branch), .is_load_o(e_is_load), .is_store_o(e_is_store),
      .is_misc_mem_o(e_is_misc_mem), .is_system_o(e_is_system),
      .e_illegal_inst_o(e_illegal)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %h want 0", out_valid); else pass_cnt++;
      total_cnt++; if (imm !== 32'h0) $display("FAIL reset_imm: got %h want 0", imm); else pass_cnt++;
      total_cnt++; if (dat_a !== 32'h0) $display("FAIL reset_dat_a: got %h want 0", dat_a); else pass_cnt++;
      total_cnt++; if (rd !== 5'd0) $display("FAIL reset_rd: got %h want 0", rd); else pass_cnt++;
      total_cnt++; if (flags !== 10'd0) $display("FAIL reset_flags: got %h want 0", flags); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %h want 1", in_ready); else pass_cnt++;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_addi();
      instruction = 32'h00500093;   // addi x1, x0, 5
      pc          = 32'h100;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL addi_in_ready: got %h want 1", in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %h want 1", out_valid); else pass_cnt++;
      total_cnt++; if (is_op !== 1'b1) $display("FAIL addi_is_op: got %h want 1", is_op); else pass_cnt++;
      total_cnt++; if (rd !== 5'd1) $display("FAIL addi_rd: got %h want 1", rd); else pass_cnt++;
      total_cnt++; if (dat_a !== 32'h0) $display("FAIL addi_dat_a: got %h want 0", dat_a); else pass_cnt++;
      total_cnt++; if (dat_b !== 32'h5) $display("FAIL addi_dat_b: got %h want 5", dat_b); else pass_cnt++;
      total_cnt++; if (imm !== 32'h5) $display("FAIL addi_imm: got %h want 5", imm); else pass_cnt++;
      total_cnt++; if (alu_op !== 4'h0) $display("FAIL addi_alu_op: got %h want 0", alu_op); else pass_cnt++;
      total_cnt++; if (illegal !== 1'b0) $display("FAIL addi_illegal: got %h want 0", illegal); else pass_cnt++;
      in_valid = 1'b0;
      tick();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL addi_drain: got %h want 0", out_valid); else pass_cnt++;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_forwarding();
      rf_we = 1'b1; rd_in = 5'd2; rf_wd = 32'h1234;
      tick();
      rf_we = 1'b0;
      instruction = 32'h002101B3;   // add x3, x2, x2
      fwd_valid   = 2'b11;
      fwd_rd      = {5'd2, 5'd2};
      fwd_dat     = {32'h0000BBBB, 32'h0000AAAA};
      in_valid    = 1'b1;
      tick();
      total_cnt++; if (dat_a !== 32'hAAAA) $display("FAIL fwd_prio_a: got %h want aaaa", dat_a); else pass_cnt++;
      total_cnt++; if (dat_b !== 32'hAAAA) $display("FAIL fwd_prio_b: got %h want aaaa", dat_b); else pass_cnt++;
      total_cnt++; if (store_dat !== 32'hAAAA) $display("FAIL fwd_prio_store: got %h want aaaa", store_dat); else pass_cnt++;
      total_cnt++; if (rd !== 5'd3) $display("FAIL fwd_rd: got %h want 3", rd); else pass_cnt++;
      fwd_valid = 2'b10;
      tick();
      total_cnt++; if (dat_a !== 32'hBBBB) $display("FAIL fwd_src1_a: got %h want bbbb", dat_a); else pass_cnt++;
      fwd_valid = 2'b00;
      tick();
      total_cnt++; if (dat_a !== 32'h1234) $display("FAIL fwd_none_a: got %h want 1234", dat_a); else pass_cnt++;
      total_cnt++; if (dat_b !== 32'h1234) $display("FAIL fwd_none_b: got %h want 1234", dat_b); else pass_cnt++;
      // x0 never matches a forwarding source
      instruction = 32'h000001B3;   // add x3, x0, x0
      fwd_valid   = 2'b01;
      fwd_rd      = 10'd0;
      tick();
      total_cnt++; if (dat_a !== 32'h0) $display("FAIL fwd_x0_a: got %h want 0", dat_a); else pass_cnt++;
      in_valid  = 1'b0;
      fwd_valid = 2'b00;
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_rf_write_timing();
      instruction = 32'h00120293;   // addi x5, x4, 1
      rf_we = 1'b1; rd_in = 5'd4; rf_wd = 32'h77;
      in_valid = 1'b1;
      tick();
      total_cnt++; if (dat_a !== 32'h0) $display("FAIL rf_same_cycle: got %h want 0", dat_a); else pass_cnt++;
      total_cnt++; if (dat_b !== 32'h1) $display("FAIL rf_imm_b: got %h want 1", dat_b); else pass_cnt++;
      rf_we = 1'b0;
      tick();
      total_cnt++; if (dat_a !== 32'h77) $display("FAIL rf_next_cycle: got %h want 77", dat_a); else pass_cnt++;
      in_valid = 1'b0;
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_load_use();
      instruction = 32'h00028333;   // add x6, x5, x0
      fwd_valid   = 2'b01;
      fwd_rd      = {5'd0, 5'd5};
      fwd_pending = 2'b01;
      in_valid    = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL lu_in_ready: got %h want 0", in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL lu_bubble: got %h want 0", out_valid); else pass_cnt++;
      fwd_pending = 2'b00;
      fwd_dat     = {32'h0, 32'h55};
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL lu_release_ready: got %h want 1", in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL lu_accept: got %h want 1", out_valid); else pass_cnt++;
      total_cnt++; if (dat_a !== 32'h55) $display("FAIL lu_dat_a: got %h want 55", dat_a); else pass_cnt++;
      total_cnt++; if (rd !== 5'd6) $display("FAIL lu_rd: got %h want 6", rd); else pass_cnt++;
      // lui does not read rs1; its rs1 field (x8) matching a pending source is ignored
      instruction = 32'h123453B7;   // lui x7, 0x12345
      fwd_rd      = {5'd0, 5'd8};
      fwd_pending = 2'b01;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL lu_unused_rs: got %h want 1", in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (is_lui !== 1'b1) $display("FAIL lui_flag: got %h want 1", is_lui); else pass_cnt++;
      total_cnt++; if (imm !== 32'h12345000) $display("FAIL lui_imm: got %h want 12345000", imm); else pass_cnt++;
      total_cnt++; if (dat_a !== 32'h0) $display("FAIL lui_dat_a: got %h want 0", dat_a); else pass_cnt++;
      in_valid = 1'b0; fwd_valid = 2'b00; fwd_pending = 2'b00;
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_stall();
      instruction = 32'h00500093;   // addi x1, x0, 5
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      out_ready   = 1'b0;
      instruction = 32'h00700493;   // addi x9, x0, 7
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %h want 0", in_ready); else pass_cnt++;
      for (int c = 0; c < 3; c++) begin
         tick();
         total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %h want 1", c, out_valid); else pass_cnt++;
         total_cnt++; if (rd !== 5'd1) $display("FAIL stall_rd[%0d]: got %h want 1", c, rd); else pass_cnt++;
         total_cnt++; if (imm !== 32'h5) $display("FAIL stall_imm[%0d]: got %h want 5", c, imm); else pass_cnt++;
      end
      out_ready = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %h want 1", in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (rd !== 5'd9) $display("FAIL stall_next_rd: got %h want 9", rd); else pass_cnt++;
      total_cnt++; if (imm !== 32'h7) $display("FAIL stall_next_imm: got %h want 7", imm); else pass_cnt++;
      in_valid = 1'b0;
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_flush();
      instruction = 32'h00500093;
      in_valid = 1'b1;
      tick();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL flush_pre_valid: got %h want 1", out_valid); else pass_cnt++;
      instruction = 32'h00700493;
      flush = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %h want 1", in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %h want 0", out_valid); else pass_cnt++;
      flush = 1'b0; in_valid = 1'b0;
      tick();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_dropped: got %h want 0", out_valid); else pass_cnt++;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset_mid_stall();
      instruction = 32'h00500093;
      in_valid = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_stall_valid: got %h want 0", out_valid); else pass_cnt++;
      total_cnt++; if (rd !== 5'd0) $display("FAIL rst_stall_rd: got %h want 0", rd); else pass_cnt++;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_illegal();
      in_valid = 1'b1;
      instruction = 32'hFFFFFFFF;
      tick();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL ill_valid: got %h want 1", out_valid); else pass_cnt++;
      total_cnt++; if (illegal !== 1'b1) $display("FAIL ill_flag: got %h want 1", illegal); else pass_cnt++;
      total_cnt++; if (flags !== 10'd0) $display("FAIL ill_classes: got %h want 0", flags); else pass_cnt++;
      instruction = 32'h00000000;   // opcode[1:0] = 00
      tick();
      total_cnt++; if (illegal !== 1'b1) $display("FAIL ill_low_bits: got %h want 1", illegal); else pass_cnt++;
      instruction = 32'h00208A33;   // add x20, x1, x2
      tick();
      total_cnt++; if (illegal !== 1'b0) $display("FAIL x20_rv32i_illegal: got %h want 0", illegal); else pass_cnt++;
      total_cnt++; if (is_op !== 1'b1) $display("FAIL x20_rv32i_op: got %h want 1", is_op); else pass_cnt++;
      total_cnt++; if (e_illegal !== 1'b1) $display("FAIL x20_e_illegal: got %h want 1", e_illegal); else pass_cnt++;
      total_cnt++; if (e_flags !== 10'd0) $display("FAIL x20_e_classes: got %h want 0", e_flags); else pass_cnt++;
      instruction = 32'h002101B3;   // add x3, x2, x2
      tick();
      total_cnt++; if (e_illegal !== 1'b0) $display("FAIL e_legal: got %h want 0", e_illegal); else pass_cnt++;
      in_valid = 1'b0;
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_formats();
      in_valid = 1'b1;
      instruction = 32'h0020A423;   // sw x2, 8(x1)
      tick();
      total_cnt++; if (is_store !== 1'b1) $display("FAIL sw_flag: got %h want 1", is_store); else pass_cnt++;
      total_cnt++; if (imm !== 32'h8) $display("FAIL sw_imm: got %h want 8", imm); else pass_cnt++;
      total_cnt++; if (dat_b !== 32'h8) $display("FAIL sw_dat_b: got %h want 8", dat_b); else pass_cnt++;
      total_cnt++; if (funct3 !== 3'd2) $display("FAIL sw_funct3: got %h want 2", funct3); else pass_cnt++;
      instruction = 32'hFE208EE3;   // beq x1, x2, -4
      tick();
      total_cnt++; if (is_branch !== 1'b1) $display("FAIL beq_flag: got %h want 1", is_branch); else pass_cnt++;
      total_cnt++; if (imm !== 32'hFFFFFFFC) $display("FAIL beq_imm: got %h want fffffffc", imm); else pass_cnt++;
      instruction = 32'h008000EF;   // jal x1, +8
      pc = 32'h200;
      tick();
      total_cnt++; if (is_jal !== 1'b1) $display("FAIL jal_flag: got %h want 1", is_jal); else pass_cnt++;
      total_cnt++; if (imm !== 32'h8) $display("FAIL jal_imm: got %h want 8", imm); else pass_cnt++;
      total_cnt++; if (dat_a !== 32'h200) $display("FAIL jal_dat_a: got %h want 200", dat_a); else pass_cnt++;
      total_cnt++; if (dat_b !== 32'h4) $display("FAIL jal_dat_b: got %h want 4", dat_b); else pass_cnt++;
      instruction = 32'h00001097;   // auipc x1, 1
      pc = 32'h300;
      tick();
      total_cnt++; if (is_auipc !== 1'b1) $display("FAIL auipc_flag: got %h want 1", is_auipc); else pass_cnt++;
      total_cnt++; if (imm !== 32'h1000) $display("FAIL auipc_imm: got %h want 1000", imm); else pass_cnt++;
      total_cnt++; if (dat_a !== 32'h300) $display("FAIL auipc_dat_a: got %h want 300", dat_a); else pass_cnt++;
      instruction = 32'h402081B3;   // sub x3, x1, x2
      tick();
      total_cnt++; if (alu_op !== 4'h8) $display("FAIL sub_alu_op: got %h want 8", alu_op); else pass_cnt++;
      instruction = 32'h4030D093;   // srai x1, x1, 3
      tick();
      total_cnt++; if (alu_op !== 4'hD) $display("FAIL srai_alu_op: got %h want d", alu_op); else pass_cnt++;
      instruction = 32'h40000093;   // addi x1, x0, 0x400
      tick();
      total_cnt++; if (alu_op !== 4'h0) $display("FAIL addi_bit30_alu_op: got %h want 0", alu_op); else pass_cnt++;
      total_cnt++; if (imm !== 32'h400) $display("FAIL addi_bit30_imm: got %h want 400", imm); else pass_cnt++;
      instruction = 32'h305110F3;   // csrrw x1, 0x305, x2
      tick();
      total_cnt++; if (is_system !== 1'b1) $display("FAIL csr_flag: got %h want 1", is_system); else pass_cnt++;
      total_cnt++; if (csr_addr !== 12'h305) $display("FAIL csr_addr: got %h want 305", csr_addr); else pass_cnt++;
      in_valid = 1'b0;
      tick();
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_addi();
      test_forwarding();
      test_rf_write_timing();
      test_load_use();
      test_stall();
      test_flush();
      test_reset_mid_stall();
      test_illegal();
      test_formats();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Parametrised decode stage successor. Decodes a raw RV32I-class instruction, reads an internal register file and resolves operands through N prioritised forwarding sources.
- Detects load-use hazards and registers all results into an ID/EX pipeline register with valid/ready handshakes on both sides.
- Sits between stage_if and stage_ex. Flush comes from branch/exception logic.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- NUM_REGS, 32, architectural registers (16 for E-variant, 32 otherwise).
- NUM_FWD, 2, forwarding sources. Index 0 is highest priority (youngest).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  instruction/pc valid from IF
- in_ready_o  out  1  ID accepts instruction this cycle
- instruction_i  in  32  raw instruction
- pc_i  in  XLEN  instruction address
- flush_i  in  1  kill in-flight and incoming instruction
- rf_we_i  in  1  write-back enable
- rd_i  in  5  write-back register
- rf_wd_i  in  XLEN  write-back data
- fwd_valid_i  in  NUM_FWD  forwarding source holds a register-writing instruction
- fwd_pending_i  in  NUM_FWD  source data not yet available (load in flight)
- fwd_rd_i  in  5*NUM_FWD  destination per source
- fwd_dat_i  in  XLEN*NUM_FWD  data per source
- out_valid_o  out  1  ID/EX register holds valid instruction
- out_ready_i  in  1  EX accepts
- funct3_o  out  3
- rs1_o, rs2_o, rd_o  out  5 each
- alu_op_o  out  4  {funct7[5] for OP/shift, funct3}; ADD (0000) for non-ALU classes
- dat_a_o, dat_b_o  out  XLEN  ALU operands
- store_dat_o  out  XLEN  forwarded rs2 value
- imm_o  out  XLEN  sign-extended immediate
- csr_addr_o  out  12
- is_op_o, is_lui_o, is_auipc_o, is_jal_o, is_jalr_o, is_branch_o, is_load_o, is_store_o, is_misc_mem_o, is_system_o  out  1 each  one-hot class
- e_illegal_inst_o  out  1

Behaviour:
- Reset: out_valid_o=0 and every registered output 0. All register-file entries cleared.
- Register file: write on posedge when rf_we_i && rd_i!=0 && rd_i<NUM_REGS. x0 reads 0 always.
- Decode (combinational, registered on accept):
  - Immediate formats I/S/B/U/J, sign-extended to XLEN.
  - Illegal when opcode[1:0]!=2'b11, opcode unknown, or any used rs/rd >= NUM_REGS.
  - An illegal instruction still propagates with e_illegal_inst_o=1 and all class flags 0.
- Operand source rules:
  - Operand A = register for OP/OP-IMM/JALR/BRANCH/LOAD/STORE; pc for AUIPC/JAL; 0 for LUI.
  - Operand B = register for OP/BRANCH; constant 4 for JAL/JALR (link); imm otherwise.
- Forwarding, per rs:
  - A source matches when fwd_valid_i[k] && fwd_rd_i[k]==rs && rs!=0.
  - The lowest matching k wins and overrides RF data.
  - No match uses RF data.
- Hazard:
  - Raised when in_valid_i and the winning match for any used rs has fwd_pending_i=1.
  - Sources only, unused rs fields ignored.
- Handshake:
  - adv = out_ready_i || !out_valid_o.
  - in_ready_o = adv && !hazard.
- Register update:
  - flush_i: out_valid_o<=0 next cycle. in_ready_o=1 and the incoming instruction is dropped. Highest priority.
  - Otherwise, when adv: out_valid_o <= in_valid_i && !hazard, and payload loads when accepted. A hazard inserts a bubble.
  - Otherwise (!adv): all outputs hold stable.
- Latency: 1 cycle from accept to out_valid_o.
- Reset mid-stall clears the register to out_valid_o=0.

Optional Feature:
- RF_WRITE_BYPASS_EN defined: a same-cycle RF write to the register being read returns rf_wd_i (write-through), below all forwarding sources in priority.
- Undefined: reads return the old contents. The write is visible from the next cycle.

Test Plan:
- ADDI x1,x0,5 (0x00500093), pc=0x100, out_ready_i=1 -> next cycle: out_valid_o=1, is_op_o=1, rd_o=1, dat_a_o=0, dat_b_o=5, imm_o=5.
- Write x2=0x1234 via rf_we_i, then ADD x3,x2,x2 with fwd_valid_i[0]=1, fwd_rd_i[0]=2, fwd_dat_i[0]=0xAAAA, and fwd_valid_i[1]=1 to x2 with 0xBBBB -> dat_a_o=dat_b_o=0xAAAA. With fwd_valid_i cleared -> 0x1234.
- Load-use: fwd_pending_i[0]=1 for rd=5, in instruction uses rs1=5 -> in_ready_o=0 and a bubble (out_valid_o=0). Pending drops -> accepted next cycle.
- out_ready_i=0 with out_valid_o=1 -> in_ready_o=0 and all outputs stable over 3 cycles. Release -> next instruction loads.
- flush_i pulsed while out_valid_o=1 and in_valid_i=1 -> out_valid_o=0 next cycle. Instruction dropped.
- Instruction 0xFFFFFFFF -> e_illegal_inst_o=1 with all class flags 0. NUM_REGS=16: ADD x20,... -> e_illegal_inst_o=1.
